// File: rtl/seq_pc_controller.sv
// rtl/seq_pc_controller.sv - SEQ Y86-64 program counter and status sequencer
//
// Purpose: owns the architectural PC and processor status for the single-cycle
// SEQ datapath. Commits one instruction per clock while running and stops on
// halt, invalid instruction or memory fault.
//
// Optional feature macro: SEQ_INSTR_COUNT_EN (committed-instruction counter).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               level; leaves IDLE when sampled high
//   icode, cnd          decoded icode at PC, jXX condition
//   valC, valP, valM    next-PC candidates from fetch / memory
//   halt, imem_error,
//   instr_valid,
//   dmem_error          stop conditions
//   PC                  current program counter
//   stat                1=AOK 2=HLT 3=ADR 4=INS
//   running             high only in RUN
//   cycle_count         saturating count of RUN cycles
//   instr_count         saturating count of commits (0 without the macro)

module seq_pc_controller #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  input  logic        halt,
  input  logic        imem_error,
  input  logic        instr_valid,
  input  logic        dmem_error,
  output logic [63:0] PC,
  output logic [2:0]  stat,
  output logic        running,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] ICODE_JXX  = 4'd7;
  localparam logic [3:0] ICODE_CALL = 4'd8;
  localparam logic [3:0] ICODE_RET  = 4'd9;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic        running_q, running_d;
  logic [31:0] cycle_q, cycle_d;
  logic [63:0] new_pc;

  always_comb begin
    new_pc = valP;
    case (icode)
      ICODE_CALL: new_pc = valC;
      ICODE_JXX:  new_pc = cnd ? valC : valP;
      ICODE_RET:  new_pc = valM;
      default:    new_pc = valP;
    endcase
  end

  // Stop conditions are checked in priority order; on any of them the PC is
  // left pointing at the offending instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    cycle_d = cycle_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;
        if (imem_error) begin
          state_d = S_FAULT;
          stat_d  = STAT_ADR;
        end else if (!instr_valid) begin
          state_d = S_FAULT;
          stat_d  = STAT_INS;
        end else if (dmem_error) begin
          state_d = S_FAULT;
          stat_d  = STAT_ADR;
        end else if (halt) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else begin
          pc_d = new_pc;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      stat_q    <= STAT_AOK;
      running_q <= 1'b0;
      cycle_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      running_q <= running_d;
      cycle_q   <= cycle_d;
    end
  end

`ifdef SEQ_INSTR_COUNT_EN
  logic [31:0] instr_q, instr_d;
  logic        commit;

  // A commit is a RUN edge with none of the stop conditions present.
  assign commit = (state_q == S_RUN) && !imem_error && instr_valid &&
                  !dmem_error && !halt;

  always_comb begin
    instr_d = instr_q;
    if (commit && (instr_q != 32'hFFFF_FFFF)) instr_d = instr_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) instr_q <= 32'd0;
    else       instr_q <= instr_d;
  end

  assign instr_count = instr_q;
`else
  assign instr_count = 32'd0;
`endif

  assign PC          = pc_q;
  assign stat        = stat_q;
  assign running     = running_q;
  assign cycle_count = cycle_q;

endmodule
